// File: rtl/pc_sequencer.sv
// Program counter sequencer: stall/ret/call/jump/branch/sequential.
// Return-address stack is built only when PC_SEQ_RAS_EN is defined.
module pc_sequencer #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VEC = 0,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             jump,
    input  logic             branch,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] offset,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic             ras_full,
    output logic             ras_empty,
    output logic             ras_err
);

    logic [WIDTH-1:0] seq;
    logic [WIDTH-1:0] ras_top;
    logic ret_en;
    logic do_stall;
    logic do_ret;
    logic do_call;
    logic do_jump;
    logic do_branch;

    assign seq = pc + STEP;

    // Priority resolved up front so the decoder below sees one-hot selects
    assign do_stall  = stall;
    assign do_ret    = ret_en & ~stall;
    assign do_call   = call & ~stall & ~ret_en;
    assign do_jump   = jump & ~stall & ~ret_en & ~call;
    assign do_branch = branch & ~stall & ~ret_en & ~call & ~jump;

    always_comb begin
        pc_next = seq;
        unique case (1'b1)
            do_stall:  pc_next = pc;
            do_ret:    pc_next = ras_empty ? seq : ras_top;
            do_call:   pc_next = target;
            do_jump:   pc_next = target;
            do_branch: pc_next = pc + offset;
            default:   pc_next = seq;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_VEC;
        end else begin
            pc <= pc_next;
        end
    end

`ifdef PC_SEQ_RAS_EN
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int AW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] stack [RAS_DEPTH];
    logic [CW-1:0] count;
    logic err;
    logic push;
    logic pop;

    assign ret_en    = ret;
    assign ras_full  = count == CW'(RAS_DEPTH);
    assign ras_empty = count == '0;
    assign ras_err   = err;
    assign ras_top   = stack[AW'(count - CW'(1))];
    assign push      = do_call & ~ras_full;
    assign pop       = do_ret & ~ras_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (push) begin
                count <= count + CW'(1);
            end else if (pop) begin
                count <= count - CW'(1);
            end
            if ((do_call & ras_full) | (do_ret & ras_empty)) begin
                err <= 1'b1;
            end
        end
    end

    // Entries are left stale on reset; occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (push) begin
            stack[AW'(count)] <= seq;
        end
    end
`else
    logic unused_ras;

    assign ret_en     = 1'b0;
    assign ras_top    = '0;
    assign ras_full   = 1'b0;
    assign ras_empty  = 1'b1;
    assign ras_err    = 1'b0;
    assign unused_ras = ret | (RAS_DEPTH > 16);
`endif

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, PC and address width in bits.
REQ-002 Parameter STEP, default 1, sequential increment added to pc each advance.
REQ-003 Parameter RESET_VEC, default 0, pc value loaded on reset.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries; legal range 2..16.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 stall  input  1  hold pc and stack unchanged this cycle.
REQ-008 jump  input  1  load pc from target.
REQ-009 branch  input  1  add offset to pc.
REQ-010 call  input  1  push pc+STEP, then load pc from target.
REQ-011 ret  input  1  pop stack top into pc.
REQ-012 target  input  WIDTH  absolute destination for jump/call.
REQ-013 offset  input  WIDTH  two's-complement signed displacement for branch.
REQ-014 pc  output  WIDTH  registered current program counter.
REQ-015 pc_next  output  WIDTH  combinational value pc takes at next edge.
REQ-016 ras_full  output  1  stack holds RAS_DEPTH entries.
REQ-017 ras_empty  output  1  stack holds zero entries.
REQ-018 ras_err  output  1  sticky flag: overflow or underflow occurred.

Function
REQ-019 Command priority each cycle SHALL be: stall > ret > call > jump > branch > sequential; lower-priority requests in the same cycle are ignored.
REQ-020 Sequential: pc_next = pc + STEP, one-cycle latency from edge to pc.
REQ-021 jump: pc_next = target; branch: pc_next = pc + offset (sign-interpreted).
REQ-022 All arithmetic SHALL be modulo 2^WIDTH; wrap from max value to low values without flag or stall.
REQ-023 stall: pc_next = pc; stack pointer, contents and ras_err unchanged.
REQ-024 call with stack not full: push pc+STEP (mod 2^WIDTH), pc_next = target.
REQ-025 call with stack full: no push, contents unchanged, pc_next = target, ras_err set.
REQ-026 ret with stack not empty: pc_next = top entry, entry removed.
REQ-027 ret with stack empty: pc_next = pc + STEP, ras_err set.
REQ-028 Stack SHALL be LIFO; ras_full/ras_empty derived from registered occupancy count, updated same edge as pc.
REQ-029 ras_err SHALL remain set until reset.
REQ-030 pc_next SHALL reflect current inputs combinationally; pc SHALL equal previous cycle's pc_next.

Reset
REQ-031 On rst assertion, immediately and independent of clk: pc = RESET_VEC, occupancy 0, ras_empty = 1, ras_full = 0, ras_err = 0.
REQ-032 Reset mid-sequence SHALL discard all stack contents; stack entry storage need not be cleared.
REQ-033 First advance after rst deassertion SHALL occur on the first rising clk edge with rst low.

Configuration
REQ-034 Macro PC_SEQ_RAS_EN SHALL compile in the return-address stack.
REQ-035 With PC_SEQ_RAS_EN defined: behaviour per REQ-024..REQ-029.
REQ-036 Without PC_SEQ_RAS_EN: no stack storage; call behaves as jump; ret ignored (falls to next priority); ras_full = 0, ras_empty = 1, ras_err = 0 constantly.

Verification
REQ-037 rst pulse, then 5 idle cycles, WIDTH=32, STEP=1, RESET_VEC=0 -> pc sequence 0,1,2,3,4,5; asserting rst mid-cycle forces pc=0 without clk edge.
REQ-038 pc=0xFFFFFFFE, sequential x3 -> pc 0xFFFFFFFF, 0x00000000, 0x00000001, ras_err=0.
REQ-039 pc=0x100, branch with offset=0xFFFFFFF0 -> pc=0xF0; jump+branch same cycle target=0x40 -> pc=0x40; stall+jump -> pc unchanged.
REQ-040 RAS enabled, DEPTH=4: call at pc=0x10 target=0x200, then ret -> pc 0x200 then 0x11, ras_empty=1, ras_err=0.
REQ-041 RAS enabled, DEPTH=4: 5 calls -> ras_full=1 after 4th, ras_err=1 after 5th; 4 rets return pushed addresses in reverse order; 5th ret -> pc+1, ras_err stays 1.
REQ-042 RAS disabled build: call target=0x80 -> pc=0x80; ret alone -> pc=0x81; ras_err=0 throughout.
